// File: rtl/barrel_shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
//   shift_op_t : per-beat operation select (ROT, LOGIC, ARITH, RSVD)
//   DIR_LEFT / DIR_RIGHT : direction encodings
//   W(n)       : data width for a log2 width of n
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        ROT   = 2'b00,
        LOGIC = 2'b01,
        ARITH = 2'b10,
        RSVD  = 2'b11
    } shift_op_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic int W(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One combinational step of the barrel shifter: conditionally shifts or
// rotates by 2**(I-1).
//   in_data  : operand entering this step
//   en       : amount bit I-1; when low the operand passes through
//   dir      : DIR_LEFT / DIR_RIGHT
//   op       : shift_op_t; RSVD behaves as LOGIC
//   sign     : MSB of the original operand, used as arithmetic fill
//   out_data : result of this step
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int N = 3,
    parameter int I = 1
) (
    input  logic [W(N)-1:0] in_data,
    input  logic            en,
    input  logic            dir,
    input  shift_op_t       op,
    input  logic            sign,
    output logic [W(N)-1:0] out_data
);

    localparam int DW = W(N);
    localparam int D  = 2 ** (I - 1);

    always_comb begin
        out_data = in_data;
        if (en) begin
            if (op == ROT) begin
                out_data = (dir == DIR_RIGHT) ? ((in_data >> D) | (in_data << (DW - D)))
                                              : ((in_data << D) | (in_data >> (DW - D)));
            end else if (op == ARITH && dir == DIR_RIGHT) begin
                // Fill from the carried original MSB, not the current one,
                // so every step extends the same sign.
                out_data = (in_data >> D) | ({DW{sign}} << (DW - D));
            end else begin
                out_data = (dir == DIR_RIGHT) ? (in_data >> D) : (in_data << D);
            end
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter with valid/ready streaming and bubble collapsing.
// Stage i applies the 2**(i-1) step; control and tag ride with the beat.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_data, in_amt       : operand and distance (0..W-1)
//   in_dir, in_op, in_tag : direction, shift_op_t, sideband tag
//   out_valid/out_ready   : output handshake
//   out_data, out_tag     : registered result and its tag
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int N     = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W(N)-1:0]  in_data,
    input  logic [N-1:0]     in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W(N)-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int DW = W(N);

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [N-1:0]     amt;
        logic             dir;
        shift_op_t        op;
        logic             sign;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t         in_beat;
    beat_t         stg_in  [1:N];
    beat_t         nxt     [1:N];
    beat_t         pipe_q  [1:N];
    logic [DW-1:0] shifted [1:N];
    logic [N:1]    vld_pipe;
    logic [N:1]    stg_vld;
    logic [N:1]    rdy;

    always_comb begin
        in_beat      = '0;
        in_beat.data = in_data;
        in_beat.amt  = in_amt;
        in_beat.dir  = in_dir;
        in_beat.op   = shift_op_t'(in_op);
        in_beat.sign = in_data[DW-1];
        in_beat.tag  = in_tag;
    end

    always_comb begin
        stg_in[1]  = in_beat;
        stg_vld[1] = in_valid;
        for (int i = 2; i <= N; i++) begin
            stg_in[i]  = pipe_q[i-1];
            stg_vld[i] = vld_pipe[i-1];
        end
    end

    // ready_i = !valid_i || ready_(i+1), flattened: a stage is blocked only
    // when it and every stage below it are full and the sink stalls.
    always_comb begin
        logic full;
        full = 1'b1;
        rdy  = '0;
        for (int i = N; i >= 1; i--) begin
            full   = full & vld_pipe[i];
            rdy[i] = !full || out_ready;
        end
    end

    for (genvar g = 1; g <= N; g++) begin : g_stage
        barrel_shift_stage #(.N(N), .I(g)) u_stage (
            .in_data  (stg_in[g].data),
            .en       (stg_in[g].amt[g-1]),
            .dir      (stg_in[g].dir),
            .op       (stg_in[g].op),
            .sign     (stg_in[g].sign),
            .out_data (shifted[g])
        );
    end

    always_comb begin
        for (int i = 1; i <= N; i++) begin
            nxt[i]      = stg_in[i];
            nxt[i].data = shifted[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int i = 1; i <= N; i++) pipe_q[i] <= '0;
        end else begin
            for (int i = 1; i <= N; i++) begin
                // A ready stage takes whatever is upstream, so an empty
                // upstream slot turns into a bubble here.
                if (rdy[i]) begin
                    vld_pipe[i] <= stg_vld[i];
                    if (stg_vld[i]) pipe_q[i] <= nxt[i];
                end
            end
        end
    end

    assign in_ready  = rdy[1] && !reset;
    assign out_valid = vld_pipe[N];
    assign out_data  = pipe_q[N].data;
    assign out_tag   = pipe_q[N].tag;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;
    import barrel_shift_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // N=3 instance
    logic       in_valid, in_ready, in_dir, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] in_amt;
    logic [1:0] in_op;
    logic [3:0] in_tag, out_tag;

    // N=5 instance
    logic        in_valid5, in_ready5, in_dir5, out_valid5, out_ready5;
    logic [31:0] in_data5, out_data5;
    logic [4:0]  in_amt5;
    logic [1:0]  in_op5;
    logic [3:0]  in_tag5, out_tag5;

    barrel_shift_pipe #(.N(3), .TAG_W(4)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .in_op(in_op),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    barrel_shift_pipe #(.N(5), .TAG_W(4)) dut5 (
        .clk(clk), .reset(reset), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_data(in_data5), .in_amt(in_amt5), .in_dir(in_dir5), .in_op(in_op5),
        .in_tag(in_tag5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_data(out_data5), .out_tag(out_tag5)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t q3[$];
    exp_t q5[$];
    int   popc[$];
    int   accc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   sweep_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-by-bit reference: each result bit picks its source bit directly.
    function automatic logic [31:0] bsref(input logic [31:0] d, input int w, input int k,
                                          input logic dir, input logic [1:0] op);
        logic [31:0] r;
        int s;
        r = '0;
        for (int b = 0; b < w; b++) begin
            if (dir) begin
                s = b + k;
                if (s < w)           r[b] = d[s];
                else if (op == 2'b00) r[b] = d[s-w];
                else if (op == 2'b10) r[b] = d[w-1];
                else                 r[b] = 1'b0;
            end else begin
                s = b - k;
                if (s >= 0)          r[b] = d[s];
                else if (op == 2'b00) r[b] = d[s+w];
                else                 r[b] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic send3(input logic [7:0] d, input logic [2:0] a, input logic dir,
                         input logic [1:0] op, input logic [3:0] t, input logic [7:0] e);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir; in_op = op; in_tag = t;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin chk("accept3_timeout", 0, 1); break; end
        end
        if (in_ready) begin
            q3.push_back('{{24'h0, e}, t});
            accc.push_back(cyc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send5(input logic [31:0] d, input logic [4:0] a, input logic dir,
                         input logic [1:0] op, input logic [3:0] t, input logic [31:0] e);
        int n;
        n = 0;
        in_valid5 = 1'b1; in_data5 = d; in_amt5 = a; in_dir5 = dir; in_op5 = op; in_tag5 = t;
        forever begin
            @(negedge clk);
            if (in_ready5) break;
            n++;
            if (n > 500) begin chk("accept5_timeout", 0, 1); break; end
        end
        if (in_ready5) q5.push_back('{e, t});
        @(posedge clk); #1;
        in_valid5 = 1'b0;
    endtask

    task automatic drain3();
        int n;
        n = 0;
        while (q3.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        chk("drain3_empty", q3.size(), 0);
    endtask

    task automatic drain5();
        int n;
        n = 0;
        while (q5.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        chk("drain5_empty", q5.size(), 0);
    endtask

    // Output monitors: transfers are decided at the negedge because all
    // inputs change just after the posedge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic [3:0] prev_t;

    always @(negedge clk) begin : mon3
        exp_t e;
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_data", out_data, prev_d);
                chk("hold_tag", out_tag, prev_t);
            end
            prev_stall <= out_valid && !out_ready;
            prev_d     <= out_data;
            prev_t     <= out_tag;
            if (out_valid && out_ready) begin
                if (q3.size() == 0) chk("extra_beat3", 1, 0);
                else begin
                    e = q3.pop_front();
                    chk("data3", out_data, e.data);
                    chk("tag3", out_tag, e.tag);
                    popc.push_back(cyc);
                end
            end
        end
    end

    always @(negedge clk) begin : mon5
        exp_t e;
        if (!reset && out_valid5 && out_ready5) begin
            if (q5.size() == 0) chk("extra_beat5", 1, 0);
            else begin
                e = q5.pop_front();
                chk("data5", out_data5, e.data);
                chk("tag5", out_tag5, e.tag);
            end
        end
    end

    initial begin
        int n, rise;
        logic [7:0] d8;
        logic [31:0] e32;
        reset = 1'b1;
        in_valid = 0; in_data = 0; in_amt = 0; in_dir = 0; in_op = 0; in_tag = 0; out_ready = 1;
        in_valid5 = 0; in_data5 = 0; in_amt5 = 0; in_dir5 = 0; in_op5 = 0; in_tag5 = 0; out_ready5 = 1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_out_data", out_data, 0);
        chk("post_rst_out_tag", out_tag, 0);
        @(posedge clk); #1;

        // ROT left and latency
        send3(8'b1001_0110, 3'd3, DIR_LEFT, ROT, 4'h5, 8'b1011_0100);
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            @(posedge clk);
        end
        chk("latency", n, 3);
        drain3();

        // right shifts of A4 by 2, back to back
        popc.delete();
        send3(8'hA4, 3'd2, DIR_RIGHT, ARITH, 4'h1, 8'hE9);
        send3(8'hA4, 3'd2, DIR_RIGHT, LOGIC, 4'h2, 8'h29);
        send3(8'hA4, 3'd2, DIR_RIGHT, ROT,   4'h3, 8'h29);
        drain3();
        chk("b2b_count", popc.size(), 3);
        if (popc.size() == 3) begin
            chk("b2b_gap1", popc[1] - popc[0], 1);
            chk("b2b_gap2", popc[2] - popc[1], 1);
        end

        // left of FF by 7 in LOGIC, ARITH and reserved op
        send3(8'hFF, 3'd7, DIR_LEFT, LOGIC, 4'h6, 8'h80);
        send3(8'hFF, 3'd7, DIR_LEFT, ARITH, 4'h7, 8'h80);
        send3(8'hFF, 3'd7, DIR_LEFT, RSVD,  4'h8, 8'h80);
        drain3();

        // backpressure on a full pipe
        out_ready = 1'b0;
        popc.delete();
        accc.delete();
        rise = -1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    d8  = 8'h5A + 8'(i * 37);
                    e32 = bsref({24'h0, d8}, 8, i, DIR_RIGHT, 2'b10);
                    send3(d8, 3'(i), DIR_RIGHT, ARITH, 4'(i + 8), e32[7:0]);
                end
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_accepts", accc.size(), 3);
                chk("bp_out_valid", out_valid, 1);
                @(posedge clk); #1 out_ready = 1'b1;
                rise = cyc;
                @(negedge clk);
                chk("bp_in_ready_rise", in_ready, 1);
            end
        join
        drain3();
        chk("bp_accept_count", accc.size(), 5);
        if (accc.size() == 5) chk("bp_4th_accept_cyc", accc[3], rise);
        chk("bp_pop_count", popc.size(), 5);
        if (popc.size() == 5)
            for (int i = 1; i < 5; i++) chk("bp_throughput", popc[i] - popc[i-1], 1);

        // reset with beats in flight
        out_ready = 1'b0;
        send3(8'h12, 3'd1, DIR_LEFT, LOGIC, 4'h1, 8'h24);
        send3(8'h34, 3'd1, DIR_LEFT, LOGIC, 4'h2, 8'h68);
        send3(8'h56, 3'd1, DIR_LEFT, LOGIC, 4'h3, 8'hAC);
        reset = 1'b1;
        q3.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        chk("mid_rst_in_ready_hi", in_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        send3(8'h3C, 3'd5, DIR_LEFT, ROT, 4'hC, 8'h87);
        drain3();

        // randomised sweep on both widths with random backpressure
        fork
            begin
                fork
                    begin
                        logic [7:0] d; logic [2:0] a; logic dr; logic [1:0] op; logic [3:0] t;
                        logic [31:0] e;
                        for (int i = 0; i < 300; i++) begin
                            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                            d = 8'($urandom); a = 3'($urandom); dr = 1'($urandom);
                            op = 2'($urandom); t = 4'($urandom);
                            e = bsref({24'h0, d}, 8, a, dr, op);
                            send3(d, a, dr, op, t, e[7:0]);
                        end
                    end
                    begin
                        logic [31:0] d; logic [4:0] a; logic dr; logic [1:0] op; logic [3:0] t;
                        for (int i = 0; i < 300; i++) begin
                            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                            d = $urandom; a = 5'($urandom); dr = 1'($urandom);
                            op = 2'($urandom); t = 4'($urandom);
                            send5(d, a, dr, op, t, bsref(d, 32, a, dr, op));
                        end
                    end
                join
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk); #1;
                    out_ready  = ($urandom_range(0, 3) != 0);
                    out_ready5 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready  = 1'b1;
        out_ready5 = 1'b1;
        drain3();
        drain5();
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

Pipelined, parameterised barrel shifter with a valid/ready stream interface. It supports left and right shifts and rotate, logical and arithmetic modes, selected per beat. It carries a sideband tag, sustains one beat per clock and absorbs downstream backpressure. It replaces the combinational left-rotate shifter wherever the shifter sits on a timing-critical streaming datapath.

## Interface
- N, default 3: log2 of data width; data width W = 2**N, shift amount width N.
- TAG_W, default 4: width of the sideband tag carried with each beat; must be at least 1.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat on this edge.
- in_data  input  W  operand.
- in_amt  input  N  shift or rotate distance, 0..W-1.
- in_dir  input  1  0 = left, 1 = right.
- in_op  input  2  shift_op_t: 00 ROT, 01 LOGIC, 10 ARITH, 11 reserved (treated as LOGIC).
- in_tag  input  TAG_W  sideband, returned unmodified.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W  result.
- out_tag  output  TAG_W  tag of the result beat.

## Operation
- A transfer occurs on an edge where valid && ready is high, on either side.
- The pipeline has N register stages. Stage i (1..N) holds the beat after it has been conditionally shifted by 2**(i-1).
  - Control: in_amt bit i-1 gates stage i.
  - Unused amt bits, dir, op and tag travel with the beat through the stage registers.
- Per-stage function, shift distance d = 2**(i-1):
  - ROT: bits leaving one end re-enter at the other.
  - LOGIC: zero fill.
  - ARITH, right: fill with bit W-1 of the original operand. Carry this sign bit with the beat so that every stage fills with the original MSB.
  - ARITH, left: identical to LOGIC.
- Final result for distance k:
  - ROT left: data rotated left by k; ROT right: rotated right by k.
  - LOGIC left: data << k; LOGIC right: data >> k.
  - ARITH right: signed data >>> k.
- in_amt = 0 passes the data through unchanged in every mode.
- Flow control is an elastic pipeline with per-stage bubble collapsing:
  - ready_N = !valid_N || out_ready.
  - ready_i = !valid_i || ready_(i+1).
  - in_ready = ready_1 && !reset.
- A stage loads when its upstream holds a valid beat and the stage's own ready is high. When ready is low the stage holds its data and valid.
- Beats leave in acceptance order. None are dropped or duplicated.
- The output is driven directly from the stage N registers; out_data, out_tag and out_valid are registered.
- While out_valid && !out_ready, out_data and out_tag stay stable.

## Timing
- Latency: a beat accepted on edge t is presented on out_* starting the cycle after edge t+N-1, i.e. N cycles.
- Throughput: 1 beat per clock when out_ready is held high.
- Capacity: N beats. With out_ready low, in_ready falls in the cycle after the Nth beat is accepted.
- in_ready rises combinationally in the same cycle out_ready rises when the pipe is full. This is a combinational path from out_ready to in_ready, depth N.
- Reset applied on any edge:
  - All stage valids clear; out_valid = 0 from the next cycle.
  - Data and tag registers clear: out_data = 0, out_tag = 0.
  - Beats in flight are discarded.
  - in_ready = 0 while reset is high, and 1 in the first cycle after reset deasserts.
- Simultaneous accept and emit on a full pipe is legal: the pipe advances one slot, occupancy is unchanged, and in_ready stays high.
- Reserved op 11 produces exactly the LOGIC result, with no error flag.

## Structure
- Package barrel_shift_pkg holds:
  - shift_op_t enum (ROT, LOGIC, ARITH, RSVD);
  - constants DIR_LEFT = 0, DIR_RIGHT = 1;
  - a width function W(N) = 2**N.
- Sub-module barrel_shift_stage, parameterised on N and stage index I:
  - combinational conditional shift by 2**(I-1) for a given direction, op and sign bit;
  - instantiated N times in a generate loop.
- The stage registers and valid/ready chain live in the top module.

## Test plan
- N=3, ROT left, in_data 8'b1001_0110, amt 3 -> out_data 8'b1011_0100, after 3 cycles; tag 4'h5 -> out_tag 4'h5.
- Right shift of 8'hA4 by amt 2:
  - ARITH -> 8'hE9;
  - LOGIC -> 8'h29;
  - ROT -> 8'h29;
  - beats issued back to back -> results in order on 3 consecutive cycles.
- LOGIC left of 8'hFF by amt 7 -> 8'h80; ARITH left of the same beat -> 8'h80; op 11 with the same beat -> 8'h80.
- Backpressure, full-pipe emit:
  - out_ready low and 5 beats offered -> in_ready drops after 3 accepts; out_data stays stable while out_ready is low.
  - Raise out_ready -> remaining beats emerge in order, none lost, the 4th beat accepted in the cycle out_ready rises, and 1 beat/cycle throughput is restored.
- Reset with 3 beats in flight:
  - Next cycle: out_valid = 0, out_data = 0.
  - While reset is high: in_ready = 0.
  - First cycle after reset releases: in_ready = 1, and the first beat fed afterwards emerges correct.
- Randomised sweep, all amt, dir and op, N=3 and N=5 (W=32) -> every output matches the reference model, with random out_ready toggling.
